// File: rtl/solver_pkg.sv
// Shared Solver definitions: clause geometry, loader state encoding and the
// literal layout inside one clause word (also used by the Solver evaluator).
package solver_pkg;

    localparam int CLAUSE_BIT_WIDTH = 32;
    localparam int MAX_CLAUSES      = 16;
    localparam int INDEX_WIDTH      = $clog2(MAX_CLAUSES);
    localparam int COUNT_WIDTH      = INDEX_WIDTH + 1;

    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(MAX_CLAUSES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

    // A clause word packs four literals; each literal is {negate, variable}.
    localparam int LIT_WIDTH       = 8;
    localparam int LITS_PER_CLAUSE = CLAUSE_BIT_WIDTH / LIT_WIDTH;
    localparam int LIT_VAR_WIDTH   = LIT_WIDTH - 1;
    localparam int LIT_NEG_BIT     = LIT_WIDTH - 1;

    typedef logic [CLAUSE_BIT_WIDTH-1:0] clause_t;
    typedef logic [LIT_WIDTH-1:0]        literal_t;

    function automatic literal_t clause_literal(input clause_t c, input logic [1:0] slot);
        return c[int'(slot)*LIT_WIDTH +: LIT_WIDTH];
    endfunction

    function automatic logic literal_negated(input literal_t lit);
        return lit[LIT_NEG_BIT];
    endfunction

    function automatic logic [LIT_VAR_WIDTH-1:0] literal_var(input literal_t lit);
        return lit[LIT_VAR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/clause_loader_if.sv
// Clause stream plus Solver read port between the upstream/Solver side
// (master) and the clause loader (slave).
interface clause_loader_if;
    import solver_pkg::*;

    logic                         in_start;
    logic                         in_clause_valid;
    logic [CLAUSE_BIT_WIDTH-1:0]  in_clause;
    logic                         in_clause_last;
    logic                         out_clause_ready;
    logic                         out_load_done;
    logic                         out_overflow;
    logic [INDEX_WIDTH:0]         out_num_clauses;
    logic [INDEX_WIDTH-1:0]       in_rd_index;
    logic [CLAUSE_BIT_WIDTH-1:0]  out_rd_clause;
    logic                         out_rd_valid;

    modport master (
        output in_start, in_clause_valid, in_clause, in_clause_last, in_rd_index,
        input  out_clause_ready, out_load_done, out_overflow, out_num_clauses,
               out_rd_clause, out_rd_valid
    );

    modport slave (
        input  in_start, in_clause_valid, in_clause, in_clause_last, in_rd_index,
        output out_clause_ready, out_load_done, out_overflow, out_num_clauses,
               out_rd_clause, out_rd_valid
    );

endinterface

// File: rtl/clause_ram.sv
// Clause storage: one synchronous write port and one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module clause_ram
    import solver_pkg::*;
#(
    parameter int DEPTH = MAX_CLAUSES,
    parameter int WIDTH = CLAUSE_BIT_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/clause_loader.sv
// Loads a clause set from an upstream valid/ready stream into clause RAM and
// serves indexed reads to the Solver once the set is complete.
module clause_loader
    import solver_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    clause_loader_if.slave    bus
);

    loader_state_e            state_q, state_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     overflow_q, overflow_d;
    logic                     rd_valid_q, rd_valid_d;

    logic                     ready;
    logic                     handshake;
    logic                     ram_we;
    logic [INDEX_WIDTH-1:0]   ram_waddr;
    logic [CLAUSE_BIT_WIDTH-1:0] ram_rdata;

    assign ready     = (state_q == ST_LOAD) && (count_q < FULL_COUNT);
    assign handshake = bus.in_clause_valid && ready;
    // Count never reaches FULL_COUNT while a write is possible, so the low bits address the slot.
    assign ram_waddr = count_q[INDEX_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        ram_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_start) begin
                    state_d    = ST_LOAD;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_LOAD: begin
                // A restart wins over a same-cycle beat; that beat is dropped.
                if (bus.in_start) begin
                    count_d = '0;
                end else if (handshake) begin
                    ram_we  = 1'b1;
                    count_d = count_q + COUNT_WIDTH'(1);
                    if (bus.in_clause_last) begin
                        state_d = ST_DONE;
                    end
                end else if (bus.in_clause_valid) begin
                    overflow_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.in_start) begin
                    state_d    = ST_LOAD;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // No writes happen in DONE, so a DONE-qualified read never races a write.
    always_comb begin
        rd_valid_d = (state_q == ST_DONE) && ({1'b0, bus.in_rd_index} < count_q);
    end

    clause_ram #(
        .DEPTH (MAX_CLAUSES),
        .WIDTH (CLAUSE_BIT_WIDTH),
        .AW    (INDEX_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bus.in_clause),
        .raddr (bus.in_rd_index),
        .rdata (ram_rdata)
    );

    assign bus.out_clause_ready = ready;
    assign bus.out_load_done    = (state_q == ST_DONE);
    assign bus.out_overflow     = overflow_q;
    assign bus.out_num_clauses  = count_q;
    assign bus.out_rd_valid     = rd_valid_q;
    assign bus.out_rd_clause    = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_clause_loader.sv
// Directed bench for clause_loader: reset, basic load/readback, overflow,
// exact fill, restart collision and reset during a load.
module tb_clause_loader;
    import solver_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    clause_loader_if bus ();

    clause_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.in_start = 1'b1;
        tick();
        bus.in_start = 1'b0;
        $display("start: num=%0d ready=%b", bus.out_num_clauses, bus.out_clause_ready);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        bus.in_clause_valid = 1'b1;
        bus.in_clause       = d;
        bus.in_clause_last  = last;
        tick();
        bus.in_clause_valid = 1'b0;
        bus.in_clause_last  = 1'b0;
        $display("beat: data=%h last=%b num=%0d done=%b ovf=%b", d, last,
                 bus.out_num_clauses, bus.out_load_done, bus.out_overflow);
    endtask

    task automatic read_idx(input logic [3:0] idx);
        bus.in_rd_index = idx;
        tick();
        $display("read: idx=%0d data=%h valid=%b", idx, bus.out_rd_clause, bus.out_rd_valid);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.out_clause_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.out_clause_ready); end
        n_cmp++; if (bus.out_load_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.out_load_done); end
        n_cmp++; if (bus.out_num_clauses !== 5'd0) begin n_err++; $display("FAIL reset_num: got %0d want 0", bus.out_num_clauses); end
        n_cmp++; if (bus.out_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", bus.out_rd_valid); end
        n_cmp++; if (bus.out_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.out_overflow); end
        n_cmp++; if (bus.out_rd_clause !== 32'h0) begin n_err++; $display("FAIL reset_rd_clause: got %h want 0", bus.out_rd_clause); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.out_clause_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", bus.out_clause_ready); end
    endtask

    task automatic test_basic_load();
        do_start();
        n_cmp++; if (bus.out_clause_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", bus.out_clause_ready); end
        send_beat(32'hA1, 1'b0);
        send_beat(32'hB2, 1'b0);
        send_beat(32'hC3, 1'b1);
        n_cmp++; if (bus.out_num_clauses !== 5'd3) begin n_err++; $display("FAIL basic_num: got %0d want 3", bus.out_num_clauses); end
        n_cmp++; if (bus.out_load_done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", bus.out_load_done); end
        n_cmp++; if (bus.out_clause_ready !== 1'b0) begin n_err++; $display("FAIL basic_done_ready: got %b want 0", bus.out_clause_ready); end
        read_idx(4'd1);
        n_cmp++; if (bus.out_rd_clause !== 32'hB2) begin n_err++; $display("FAIL basic_rd1_data: got %h want b2", bus.out_rd_clause); end
        n_cmp++; if (bus.out_rd_valid !== 1'b1) begin n_err++; $display("FAIL basic_rd1_valid: got %b want 1", bus.out_rd_valid); end
        read_idx(4'd0);
        n_cmp++; if (bus.out_rd_clause !== 32'hA1) begin n_err++; $display("FAIL basic_rd0_data: got %h want a1", bus.out_rd_clause); end
        read_idx(4'd2);
        n_cmp++; if (bus.out_rd_clause !== 32'hC3) begin n_err++; $display("FAIL basic_rd2_data: got %h want c3", bus.out_rd_clause); end
        read_idx(4'd3);
        n_cmp++; if (bus.out_rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_rd3_valid: got %b want 0", bus.out_rd_valid); end
        read_idx(4'd5);
        n_cmp++; if (bus.out_rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_rd5_valid: got %b want 0", bus.out_rd_valid); end
        n_cmp++; if (bus.out_rd_clause !== 32'h0) begin n_err++; $display("FAIL basic_rd5_data: got %h want 0", bus.out_rd_clause); end
    endtask

    task automatic test_overflow();
        do_start();
        for (int i = 0; i < 16; i++) send_beat(32'h100 + i, 1'b0);
        n_cmp++; if (bus.out_clause_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", bus.out_clause_ready); end
        n_cmp++; if (bus.out_num_clauses !== 5'd16) begin n_err++; $display("FAIL full_num: got %0d want 16", bus.out_num_clauses); end
        n_cmp++; if (bus.out_load_done !== 1'b0) begin n_err++; $display("FAIL full_done: got %b want 0", bus.out_load_done); end
        n_cmp++; if (bus.out_rd_valid !== 1'b0) begin n_err++; $display("FAIL full_rd_valid_in_load: got %b want 0", bus.out_rd_valid); end
        send_beat(32'hDEAD, 1'b0);
        n_cmp++; if (bus.out_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.out_overflow); end
        n_cmp++; if (bus.out_load_done !== 1'b1) begin n_err++; $display("FAIL ovf_done: got %b want 1", bus.out_load_done); end
        n_cmp++; if (bus.out_num_clauses !== 5'd16) begin n_err++; $display("FAIL ovf_num: got %0d want 16", bus.out_num_clauses); end
        read_idx(4'd15);
        n_cmp++; if (bus.out_rd_clause !== 32'h10F) begin n_err++; $display("FAIL ovf_rd15: got %h want 10f", bus.out_rd_clause); end
        read_idx(4'd0);
        n_cmp++; if (bus.out_rd_clause !== 32'h100) begin n_err++; $display("FAIL ovf_rd0: got %h want 100", bus.out_rd_clause); end
    endtask

    task automatic test_exact_fill();
        do_start();
        n_cmp++; if (bus.out_overflow !== 1'b0) begin n_err++; $display("FAIL restart_ovf_clear: got %b want 0", bus.out_overflow); end
        n_cmp++; if (bus.out_load_done !== 1'b0) begin n_err++; $display("FAIL restart_done_clear: got %b want 0", bus.out_load_done); end
        n_cmp++; if (bus.out_num_clauses !== 5'd0) begin n_err++; $display("FAIL restart_num_clear: got %0d want 0", bus.out_num_clauses); end
        for (int i = 0; i < 16; i++) send_beat(32'h200 + i, (i == 15));
        n_cmp++; if (bus.out_load_done !== 1'b1) begin n_err++; $display("FAIL fill_done: got %b want 1", bus.out_load_done); end
        n_cmp++; if (bus.out_overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf: got %b want 0", bus.out_overflow); end
        n_cmp++; if (bus.out_num_clauses !== 5'd16) begin n_err++; $display("FAIL fill_num: got %0d want 16", bus.out_num_clauses); end
        read_idx(4'd15);
        n_cmp++; if (bus.out_rd_clause !== 32'h20F) begin n_err++; $display("FAIL fill_rd15_data: got %h want 20f", bus.out_rd_clause); end
        n_cmp++; if (bus.out_rd_valid !== 1'b1) begin n_err++; $display("FAIL fill_rd15_valid: got %b want 1", bus.out_rd_valid); end
    endtask

    task automatic test_restart();
        do_start();
        send_beat(32'h301, 1'b0);
        send_beat(32'h302, 1'b0);
        n_cmp++; if (bus.out_num_clauses !== 5'd2) begin n_err++; $display("FAIL rs_num2: got %0d want 2", bus.out_num_clauses); end
        bus.in_start = 1'b1;
        send_beat(32'h3FF, 1'b0);
        bus.in_start = 1'b0;
        n_cmp++; if (bus.out_num_clauses !== 5'd0) begin n_err++; $display("FAIL rs_num0: got %0d want 0", bus.out_num_clauses); end
        n_cmp++; if (bus.out_clause_ready !== 1'b1) begin n_err++; $display("FAIL rs_ready: got %b want 1", bus.out_clause_ready); end
        send_beat(32'h3AA, 1'b1);
        n_cmp++; if (bus.out_num_clauses !== 5'd1) begin n_err++; $display("FAIL rs_num1: got %0d want 1", bus.out_num_clauses); end
        read_idx(4'd0);
        n_cmp++; if (bus.out_rd_clause !== 32'h3AA) begin n_err++; $display("FAIL rs_rd0: got %h want 3aa", bus.out_rd_clause); end
        read_idx(4'd1);
        n_cmp++; if (bus.out_rd_valid !== 1'b0) begin n_err++; $display("FAIL rs_rd1_valid: got %b want 0", bus.out_rd_valid); end
    endtask

    task automatic test_reset_mid_load();
        do_start();
        for (int i = 0; i < 5; i++) send_beat(32'h400 + i, 1'b0);
        n_cmp++; if (bus.out_num_clauses !== 5'd5) begin n_err++; $display("FAIL rml_num5: got %0d want 5", bus.out_num_clauses); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (bus.out_num_clauses !== 5'd0) begin n_err++; $display("FAIL rml_num0: got %0d want 0", bus.out_num_clauses); end
        n_cmp++; if (bus.out_clause_ready !== 1'b0) begin n_err++; $display("FAIL rml_ready: got %b want 0", bus.out_clause_ready); end
        tick();
        tick();
        n_cmp++; if (bus.out_clause_ready !== 1'b0) begin n_err++; $display("FAIL rml_ready_hold: got %b want 0", bus.out_clause_ready); end
        do_start();
        n_cmp++; if (bus.out_clause_ready !== 1'b1) begin n_err++; $display("FAIL rml_ready_after_start: got %b want 1", bus.out_clause_ready); end
    endtask

    initial begin
        n_cmp               = 0;
        n_err               = 0;
        rst_n               = 1'b0;
        bus.in_start        = 1'b0;
        bus.in_clause_valid = 1'b0;
        bus.in_clause       = '0;
        bus.in_clause_last  = 1'b0;
        bus.in_rd_index     = '0;
        test_reset();
        test_basic_load();
        test_overflow();
        test_exact_fill();
        test_restart();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
